// File: rtl/decoder_2_4_pkg.sv
// Shared types and helpers for the registered 2:4 decoder sequencer.
package decoder_2_4_pkg;

   typedef enum logic [0:0] {IDLE, HOLD} state_t;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned CODE_W = 2;

   function automatic logic [DATA_W-1:0] decode_2_4(input logic [CODE_W-1:0] code);
      logic [DATA_W-1:0] one_hot;
      one_hot       = '0;
      one_hot[code] = 1'b1;
      return one_hot;
   endfunction

endpackage

// File: rtl/hold_counter.sv
// Hold-cycle counter: synchronous load-to-zero, saturating increment,
// terminal count at HOLD_CYCLES-1.
module hold_counter #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic inc_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != TC_VAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/decoder_2_4_sequencer.sv
// Registered 2:4 decoder: accepts a code over valid/ready and holds the one-hot
// word for HOLD_CYCLES cycles, reloading without a gap on the final cycle.
module decoder_2_4_sequencer
   import decoder_2_4_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
   input  logic              Clock_In,
   input  logic              Reset_n_In,
   input  logic              Enable_In,
   input  logic              Valid_In,
   input  logic [CODE_W-1:0] Encoded_Value_In,
   output logic              Ready_Out,
   output logic              Data_3_Out,
   output logic              Data_2_Out,
   output logic              Data_1_Out,
   output logic              Data_0_Out,
   output logic              Valid_Out,
   output logic              Last_Out
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              cnt_load, cnt_inc, cnt_tc;
   logic              ready, accept;

   hold_counter #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
   ) u_hold_counter (
      .clk_i  (Clock_In),
      .rst_ni (Reset_n_In),
      .load_i (cnt_load),
      .inc_i  (cnt_inc),
      .tc_o   (cnt_tc)
   );

   always_comb begin
      ready    = Enable_In && ((state_q == IDLE) || ((state_q == HOLD) && cnt_tc));
      accept   = Valid_In && ready;
      state_d  = state_q;
      data_d   = data_q;
      valid_d  = valid_q;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      // Enable low wins over everything, including a pending reload.
      if (!Enable_In) begin
         state_d  = IDLE;
         data_d   = '0;
         valid_d  = 1'b0;
         cnt_load = 1'b1;
      end else if (accept) begin
         state_d  = HOLD;
         data_d   = decode_2_4(Encoded_Value_In);
         valid_d  = 1'b1;
         cnt_load = 1'b1;
      end else if (state_q == HOLD) begin
         if (cnt_tc) begin
            state_d  = IDLE;
            data_d   = '0;
            valid_d  = 1'b0;
            cnt_load = 1'b1;
         end else begin
            cnt_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         state_q <= IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign Ready_Out  = ready;
   assign Data_3_Out = data_q[3];
   assign Data_2_Out = data_q[2];
   assign Data_1_Out = data_q[1];
   assign Data_0_Out = data_q[0];
   assign Valid_Out  = valid_q;
   assign Last_Out   = valid_q && cnt_tc;

endmodule

// File: tb/tb_decoder_2_4_sequencer.sv
// Scoreboard bench: stimulus pushes expected {ready, last, data} per held cycle,
// monitors pop and compare on every cycle the DUT shows a valid word.
module tb_decoder_2_4_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en4, v4, en1, v1;
   logic [1:0] c4, c1;
   wire  [3:0] d4, d1;
   wire        rdy4, vo4, lo4, rdy1, vo1, lo1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] q4[$];
   logic [5:0] q1[$];

   logic [1:0] codes20 [20] = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3,
                                2'd1, 2'd2, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};

   always #5 clk = ~clk;

   decoder_2_4_sequencer #(.HOLD_CYCLES(4)) dut4 (
      .Clock_In         (clk),
      .Reset_n_In       (rst_n),
      .Enable_In        (en4),
      .Valid_In         (v4),
      .Encoded_Value_In (c4),
      .Ready_Out        (rdy4),
      .Data_3_Out       (d4[3]),
      .Data_2_Out       (d4[2]),
      .Data_1_Out       (d4[1]),
      .Data_0_Out       (d4[0]),
      .Valid_Out        (vo4),
      .Last_Out         (lo4)
   );

   decoder_2_4_sequencer #(.HOLD_CYCLES(1)) dut1 (
      .Clock_In         (clk),
      .Reset_n_In       (rst_n),
      .Enable_In        (en1),
      .Valid_In         (v1),
      .Encoded_Value_In (c1),
      .Ready_Out        (rdy1),
      .Data_3_Out       (d1[3]),
      .Data_2_Out       (d1[2]),
      .Data_1_Out       (d1[1]),
      .Data_0_Out       (d1[0]),
      .Valid_Out        (vo1),
      .Last_Out         (lo1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the HOLD_CYCLES=4 instance.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (vo4 === 1'b1) begin
            if (q4.size() == 0) begin
               check("dut4 unexpected word {rdy,last,data}", {26'd0, rdy4, lo4, d4}, 32'h0);
               check("dut4 scoreboard underflow", 32'd1, {31'd0, vo4 !== 1'b1});
            end else begin
               check("dut4 word {rdy,last,data}", {26'd0, rdy4, lo4, d4}, {26'd0, q4.pop_front()});
            end
         end else begin
            check("dut4 idle {rdy,last,data}", {26'd0, rdy4, lo4, d4}, {26'd0, en4, 5'd0});
         end
      end
   end

   // Monitor for the HOLD_CYCLES=1 instance.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (vo1 === 1'b1) begin
            if (q1.size() == 0) begin
               check("dut1 unexpected word {rdy,last,data}", {26'd0, rdy1, lo1, d1}, 32'h0);
            end else begin
               check("dut1 word {rdy,last,data}", {26'd0, rdy1, lo1, d1}, {26'd0, q1.pop_front()});
            end
         end else begin
            check("dut1 idle {rdy,last,data}", {26'd0, rdy1, lo1, d1}, {26'd0, en1, 5'd0});
         end
      end
   end

   // All tasks start and end 2 time units after a rising edge.
   task automatic idle4(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send4(input logic [1:0] code, input bit noise, input bit kill_last);
      logic [3:0] oh;
      oh = 4'b0001 << code;
      v4 = 1'b1;
      c4 = code;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         q4.push_back({(i == 3) ? !kill_last : 1'b0, (i == 3), oh});
      end
      for (int i = 0; i < 3; i++) begin
         #2;
         if (noise) begin
            v4 = 1'b1;
            c4 = code + 2'(i + 1);
         end else begin
            v4 = 1'b0;
         end
         @(posedge clk);
      end
      #2;
      if (kill_last) begin
         en4 = 1'b0;
         v4  = 1'b1;
         c4  = ~code;
      end else begin
         v4 = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en4 = 1'b0; v4 = 1'b0; c4 = 2'd0;
      en1 = 1'b0; v1 = 1'b0; c1 = 2'd0;
      #3;
      check("reset {valid,last,data}", {26'd0, vo4, lo4, d4}, 32'h0);
      check("reset ready with enable low", {31'd0, rdy4}, 32'd0);
      en4 = 1'b1;
      en1 = 1'b1;
      #1;
      check("reset ready with enable high", {30'd0, rdy4, rdy1}, 32'd3);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle4(2);

      // Single code 2 -> 0100 held 4 cycles, last on the 4th.
      send4(2'd2, 1'b0, 1'b0);
      idle4(3);
      check("single code drained", q4.size(), 32'd0);

      // Back-to-back stream 0..3 with no gap.
      for (int c = 0; c < 4; c++) send4(2'(c), 1'b0, 1'b0);
      idle4(3);
      check("stream drained", q4.size(), 32'd0);

      // Changing codes during non-final hold cycles are ignored.
      send4(2'd1, 1'b1, 1'b0);
      send4(2'd2, 1'b1, 1'b0);
      idle4(3);
      check("noise drained", q4.size(), 32'd0);

      // Enable drops in hold cycle 2 of code 3: abort on the next edge.
      v4 = 1'b1;
      c4 = 2'd3;
      @(posedge clk);
      q4.push_back({1'b0, 1'b0, 4'b1000});
      q4.push_back({1'b0, 1'b0, 4'b1000});
      #2;
      v4 = 1'b0;
      @(posedge clk);
      #2;
      en4 = 1'b0;
      v4  = 1'b1;
      c4  = 2'd0;
      idle4(4);
      check("enable abort drained", q4.size(), 32'd0);
      en4 = 1'b1;
      v4  = 1'b0;
      idle4(2);

      // Enable falls together with valid on the last hold cycle: no accept.
      send4(2'd1, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      en4 = 1'b1;
      v4  = 1'b0;
      idle4(2);
      check("enable fall on last drained", q4.size(), 32'd0);

      // Asynchronous reset in hold cycle 3 discards the word immediately.
      v4 = 1'b1;
      c4 = 2'd2;
      @(posedge clk);
      q4.push_back({1'b0, 1'b0, 4'b0100});
      q4.push_back({1'b0, 1'b0, 4'b0100});
      #2;
      v4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async reset {valid,last,data}", {26'd0, vo4, lo4, d4}, 32'h0);
      check("async reset ready", {31'd0, rdy4}, 32'd1);
      check("pre-reset words drained", q4.size(), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      send4(2'd1, 1'b0, 1'b0);
      idle4(3);
      check("post-reset drained", q4.size(), 32'd0);

      // HOLD_CYCLES=1: one code per cycle, ready throughout.
      for (int i = 0; i < 20; i++) begin
         v1 = 1'b1;
         c1 = codes20[i];
         @(posedge clk);
         q1.push_back({1'b1, 1'b1, 4'b0001 << codes20[i]});
         #2;
      end
      v1 = 1'b0;
      idle4(3);
      check("full-rate drained", q1.size(), 32'd0);
      check("final queue dut4", q4.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decoder_2_4_sequencer.md
# decoder_2_4_sequencer

Registered 2:4 decoder that converts a 2-bit encoded value back into a one-hot 4-bit vector, the inverse of the 4:2 high-priority encoder. Codes are accepted over a valid/ready handshake. Each decoded one-hot word is held on the output for a programmable number of cycles, with back-to-back reload on the final hold cycle. It sits downstream of the encoder to regenerate per-line strobes from a compact code stream.

## Interface
- `HOLD_CYCLES`, default 4: number of cycles each decoded word is driven. Legal range 1..256.
- `CNT_W`, default `$clog2(HOLD_CYCLES)` with a minimum of 1: hold-counter width. Derived; must not be overridden.

Ports:
- `Clock_In`  input  1: single clock, rising edge.
- `Reset_n_In`  input  1: asynchronous, active-low reset.
- `Enable_In`  input  1: block enable.
- `Valid_In`  input  1: `Encoded_Value_In` is valid.
- `Encoded_Value_In`  input  2: code 0..3.
- `Ready_Out`  output  1: block can accept a code this cycle (combinational).
- `Data_3_Out .. Data_0_Out`  output  1 each: decoded one-hot lines (registered).
- `Valid_Out`  output  1: decoded word is being held (registered).
- `Last_Out`  output  1: final hold cycle of the current word (combinational from registers).

## Operation
- States: IDLE and HOLD.
- Accept occurs on a rising edge where `Valid_In && Ready_Out`.
- `Ready_Out = Enable_In && (state==IDLE || (state==HOLD && cnt==HOLD_CYCLES-1))`.
- IDLE:
  - Data lines and `Valid_Out` are 0.
  - On accept: Data_n_Out = 1 where n = `Encoded_Value_In`, all other data lines 0. `Valid_Out`=1, cnt=0, next state HOLD.
- HOLD, `cnt < HOLD_CYCLES-1`:
  - cnt increments; outputs are unchanged.
  - Input is ignored and `Ready_Out`=0.
- HOLD, `cnt == HOLD_CYCLES-1` (`Last_Out`=1):
  - On accept: reload with the new code, cnt=0, stay in HOLD. There is no gap cycle.
  - Otherwise: next state IDLE, data lines 0, `Valid_Out`=0.
- `Enable_In` low in any state:
  - `Ready_Out`=0.
  - Next edge forces IDLE and clears all outputs. This aborts any hold in progress.
- Exactly one data line is high whenever `Valid_Out`=1; all data lines are 0 whenever `Valid_Out`=0.
- `Last_Out = Valid_Out && cnt==HOLD_CYCLES-1`.
- With `HOLD_CYCLES`=1, `Last_Out` equals `Valid_Out`, which allows one code per cycle at full throughput.
- cnt never exceeds `HOLD_CYCLES-1` and never wraps.

## Timing
- Reset values: state IDLE, cnt 0, all data lines 0, `Valid_Out` 0, `Last_Out` 0.
- `Ready_Out` during reset equals `Enable_In`.
- Reset assertion clears state immediately, asynchronously.
- Reset release takes effect on the next rising edge.
- Reset mid-hold discards the current word; there is no resume.
- Latency is 1 cycle. A code accepted at edge k appears on the outputs after edge k. It is held for exactly `HOLD_CYCLES` cycles, edges k+1 .. k+HOLD_CYCLES.
- Sustained throughput with `Valid_In` held high is one code every `HOLD_CYCLES` cycles.
- Simultaneous `Enable_In` falling and `Valid_In` on the last hold cycle: no accept occurs, because `Ready_Out`=0. The block goes to IDLE.
- `Valid_In` may drop without a handshake. The upstream side must hold `Encoded_Value_In` stable only in the accept cycle.

## Structure
- Package `decoder_2_4_pkg` holds:
  - `state_t` enum (IDLE, HOLD).
  - `DATA_W`=4 and `CODE_W`=2 constants.
  - A `decode_2_4` function that returns the one-hot vector for a code.
- Sub-module `hold_counter`:
  - Load and increment controls.
  - Terminal-count output at `HOLD_CYCLES-1`.
  - Parameterised on `HOLD_CYCLES`.
- The top level contains the FSM, the handshake logic and the output registers.

## Test plan
- Reset, then `Enable_In`=1 and `Valid_In`=1 with code 2 (`HOLD_CYCLES`=4) -> after 1 cycle the data lines read 0100 for exactly 4 cycles. `Last_Out` is high only in the 4th cycle, then the outputs return to 0000.
- Codes 0,1,2,3 streamed with `Valid_In` held high -> outputs 0001, 0010, 0100, 1000, each held 4 cycles with no gap. `Ready_Out` pulses only on `Last_Out` cycles.
- Drop `Enable_In` in hold cycle 2 of code 3 -> the next edge gives 0000 and `Valid_Out`=0. `Ready_Out` stays 0 until `Enable_In` returns.
- Assert `Reset_n_In`=0 mid-hold, asynchronously between edges -> outputs go to 0000 and `Valid_Out` to 0 immediately. After release, code 1 is accepted normally and gives 0010.
- `HOLD_CYCLES`=1 with 20 random codes back-to-back -> each output equals one-hot(code) one cycle later. `Ready_Out`=1 every cycle.
- `Valid_In`=1 during non-final hold cycles with changing codes -> the codes are ignored and the output is unchanged until `Last_Out`.
